sar_conv_sequencer: RTL and testbench

Multi-channel sequencer for the SAR converter datapath. It arbitrates round-robin among per-channel conversion requests and runs the sample phase. It then performs the MSB-first successive-approximation search against an external comparator and returns the result with a one-cycle valid pulse. It drives the 2-bit `StateP` phase code and the `Inc`/`Dcr` trend pulses consumed by the SAR conversion timer, so the timer measures every conversion this block runs.

---
 rtl/sar_pkg.sv | 14 +
 rtl/sar_rr_arbiter.sv | 35 +++
 rtl/sar_conv_sequencer.sv | 150 +++++++++++++++
 tb/tb_sar_conv_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR converter datapath. The phase encoding
// is common to the conversion sequencer and the conversion timer so both
// blocks interpret StateP the same way.
package sar_pkg;

   // Phase code driven on StateP by the sequencer.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_SAMPLE  = 2'b01,
      ST_CONVERT = 2'b10,
      ST_DONE    = 2'b11
   } sarState_t;

endpackage

// File: rtl/sar_rr_arbiter.sv
// Round-robin request picker for the SAR sequencer. Searches the request
// vector starting at the channel after lastPtr and wrapping at the top.
// Purely combinational; the pointer register is owned by the sequencer.
module sar_rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int IDXW     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [IDXW-1:0]     lastPtr,
   output logic [CHANNELS-1:0] grantOneHot,
   output logic [IDXW-1:0]     grantIdx,
   output logic                anyReq
);

   // Walk the channels in priority order and take the first one requesting.
   always_comb begin
      int cand;
      logic [IDXW-1:0] candIdx;
      cand        = 0;
      candIdx     = '0;
      grantOneHot = '0;
      grantIdx    = '0;
      anyReq      = 1'b0;
      for (int off = 1; off <= CHANNELS; off++) begin
         cand    = (int'(lastPtr) + off) % CHANNELS;
         candIdx = IDXW'(cand);
         if (!anyReq && req[candIdx]) begin
            anyReq               = 1'b1;
            grantOneHot[candIdx] = 1'b1;
            grantIdx             = candIdx;
         end
      end
   end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Multi-channel SAR conversion sequencer. Arbitrates round-robin between
// channel requests, runs a fixed-length sample phase, performs the MSB-first
// successive-approximation search against the external comparator and
// reports each result with a one-cycle valid pulse, an Ack to the served
// channel and Inc/Dcr trend pulses against that channel's previous result.
module sar_conv_sequencer
   import sar_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int CHANNELS      = 4,
   parameter int SAMPLE_CYCLES = 4
) (
   input  logic                        ClockT,
   input  logic                        Reset,
   input  logic [CHANNELS-1:0]         Req,
   input  logic                        CompIn,
   output logic [WIDTH-1:0]            DacOut,
   output logic [CHANNELS-1:0]         Grant,
   output logic [1:0]                  StateP,
   output logic [CHANNELS-1:0]         Ack,
   output logic [WIDTH-1:0]            DataOut,
   output logic [$clog2(CHANNELS)-1:0] ChanOut,
   output logic                        DataValid,
   output logic                        Inc,
   output logic                        Dcr,
   output logic                        Busy
);

   localparam int IDXW = $clog2(CHANNELS);
   localparam int BITW = $clog2(WIDTH);
   localparam int CNTW = $clog2(SAMPLE_CYCLES + 1);

   sarState_t             state;
   logic [CNTW-1:0]       phaseCount;
   logic [BITW-1:0]       bitIdx;
   logic [WIDTH-1:0]      trial;
   logic [IDXW-1:0]       grantIdxReg;
   logic [IDXW-1:0]       lastPtr;
   logic [WIDTH-1:0]      hist [CHANNELS];
   logic [CHANNELS-1:0]   histValid;

   logic [CHANNELS-1:0]   arbGrant;
   logic [IDXW-1:0]       arbIdx;
   logic                  arbAny;

   logic [WIDTH-1:0]      bitMask;
   logic [WIDTH-1:0]      keptTrial;
   logic [WIDTH-1:0]      nextTrial;

   sar_rr_arbiter #(
      .CHANNELS (CHANNELS),
      .IDXW     (IDXW)
   ) arbiter (
      .req         (Req),
      .lastPtr     (lastPtr),
      .grantOneHot (arbGrant),
      .grantIdx    (arbIdx),
      .anyReq      (arbAny)
   );

   assign StateP = state;

   // Decide the fate of the bit under test and line up the next trial code.
   always_comb begin
      bitMask   = WIDTH'(1) << bitIdx;
      keptTrial = CompIn ? trial : (trial & ~bitMask);
      nextTrial = keptTrial | (bitMask >> 1);
   end

   // Conversion FSM with all outputs, pointer and history registered here.
   always_ff @(posedge ClockT) begin
      if (Reset) begin
         state       <= ST_IDLE;
         Grant       <= '0;
         Ack         <= '0;
         DacOut      <= '0;
         DataOut     <= '0;
         ChanOut     <= '0;
         DataValid   <= 1'b0;
         Inc         <= 1'b0;
         Dcr         <= 1'b0;
         Busy        <= 1'b0;
         phaseCount  <= '0;
         bitIdx      <= '0;
         trial       <= '0;
         grantIdxReg <= '0;
         lastPtr     <= IDXW'(CHANNELS - 1);
         histValid   <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            hist[i] <= '0;
         end
      end else begin
         Ack       <= '0;
         DataValid <= 1'b0;
         Inc       <= 1'b0;
         Dcr       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arbAny) begin
                  state       <= ST_SAMPLE;
                  Grant       <= arbGrant;
                  grantIdxReg <= arbIdx;
                  phaseCount  <= '0;
                  DacOut      <= '0;
                  Busy        <= 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (phaseCount == CNTW'(SAMPLE_CYCLES - 1)) begin
                  state  <= ST_CONVERT;
                  trial  <= {1'b1, {(WIDTH-1){1'b0}}};
                  DacOut <= {1'b1, {(WIDTH-1){1'b0}}};
                  bitIdx <= BITW'(WIDTH - 1);
               end else begin
                  phaseCount <= phaseCount + CNTW'(1);
               end
            end
            ST_CONVERT: begin
               if (bitIdx == '0) begin
                  state                  <= ST_DONE;
                  trial                  <= keptTrial;
                  DacOut                 <= '0;
                  DataOut                <= keptTrial;
                  ChanOut                <= grantIdxReg;
                  DataValid              <= 1'b1;
                  Ack                    <= Grant;
                  Inc                    <= histValid[grantIdxReg] && (keptTrial > hist[grantIdxReg]);
                  Dcr                    <= histValid[grantIdxReg] && (keptTrial < hist[grantIdxReg]);
                  hist[grantIdxReg]      <= keptTrial;
                  histValid[grantIdxReg] <= 1'b1;
                  lastPtr                <= grantIdxReg;
               end else begin
                  trial  <= nextTrial;
                  DacOut <= nextTrial;
                  bitIdx <= bitIdx - BITW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               Grant <= '0;
               Busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Self-checking bench for sar_conv_sequencer. An ideal comparator model
// drives CompIn from a per-channel analog value; a reference model predicts
// the served channel, result, latency, DAC trial codes and trend pulses.
module tb_sar_conv_sequencer;

   localparam int WIDTH         = 8;
   localparam int CHANNELS      = 4;
   localparam int SAMPLE_CYCLES = 4;
   localparam int IDXW          = 2;
   localparam int LATENCY       = SAMPLE_CYCLES + WIDTH + 1;
   localparam int PERIOD        = SAMPLE_CYCLES + WIDTH + 2;

   logic                clockT;
   logic                reset;
   logic [CHANNELS-1:0] reqLines;
   logic                compIn;
   logic [WIDTH-1:0]    dacOut;
   logic [CHANNELS-1:0] grant;
   logic [1:0]          stateP;
   logic [CHANNELS-1:0] ack;
   logic [WIDTH-1:0]    dataOut;
   logic [IDXW-1:0]     chanOut;
   logic                dataValid;
   logic                inc;
   logic                dcr;
   logic                busy;

   logic [WIDTH-1:0]    analog [CHANNELS];
   logic [WIDTH-1:0]    modelHist [CHANNELS];
   bit                  modelValid [CHANNELS];
   int                  modelLast;
   logic [WIDTH-1:0]    modelLastData;

   int                  cyc;
   int                  testsRun;
   int                  failCount;

   sar_conv_sequencer #(
      .WIDTH         (WIDTH),
      .CHANNELS      (CHANNELS),
      .SAMPLE_CYCLES (SAMPLE_CYCLES)
   ) dut (
      .ClockT    (clockT),
      .Reset     (reset),
      .Req       (reqLines),
      .CompIn    (compIn),
      .DacOut    (dacOut),
      .Grant     (grant),
      .StateP    (stateP),
      .Ack       (ack),
      .DataOut   (dataOut),
      .ChanOut   (chanOut),
      .DataValid (dataValid),
      .Inc       (inc),
      .Dcr       (dcr),
      .Busy      (busy)
   );

   // Free-running clock.
   initial begin
      clockT = 1'b0;
      forever #5 clockT = ~clockT;
   end

   // Cycle counter used to measure latency and spacing.
   initial cyc = 0;
   always @(posedge clockT) cyc <= cyc + 1;

   // Ideal comparator: the granted channel's analog level against the DAC.
   always_comb begin
      compIn = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant[i]) compIn = (analog[i] >= dacOut);
      end
   end

   // Watchdog so the bench always terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // First requesting channel after the last served one, wrapping around.
   function automatic int rrPick(input logic [CHANNELS-1:0] r, input int last);
      for (int off = 1; off <= CHANNELS; off++) begin
         int c;
         c = (last + off) % CHANNELS;
         if (r[IDXW'(c)]) return c;
      end
      return -1;
   endfunction

   // Trial code presented while bit k is tested when the answer is v:
   // bits above k already resolved to v's bits, bit k set, lower bits clear.
   function automatic logic [WIDTH-1:0] dacExpected(input logic [WIDTH-1:0] v, input int k);
      int hi;
      hi = (int'(v) >> (k + 1)) << (k + 1);
      return WIDTH'(hi | (1 << k));
   endfunction

   task automatic clearModel();
      for (int i = 0; i < CHANNELS; i++) begin
         modelHist[i]  = '0;
         modelValid[i] = 1'b0;
      end
      modelLast     = CHANNELS - 1;
      modelLastData = '0;
   endtask

   task automatic checkResetState();
      checkOutput("rstStateP", 32'(stateP), 32'(0));
      checkOutput("rstGrant", 32'(grant), 32'(0));
      checkOutput("rstAck", 32'(ack), 32'(0));
      checkOutput("rstDacOut", 32'(dacOut), 32'(0));
      checkOutput("rstDataOut", 32'(dataOut), 32'(0));
      checkOutput("rstChanOut", 32'(chanOut), 32'(0));
      checkOutput("rstFlags", 32'({dataValid, inc, dcr, busy}), 32'(0));
   endtask

   task automatic applyReset();
      @(negedge clockT);
      reset    = 1'b1;
      reqLines = '0;
      repeat (3) @(negedge clockT);
      reset = 1'b0;
      clearModel();
      checkResetState();
   endtask

   // Requests are already on reqLines at the current negedge (cycle startCyc,
   // DUT idle). Follows one conversion to its DONE cycle and checks it.
   task automatic applyStimulus(input int startCyc, input bit holdReq, input int dropAfter, output int doneCyc);
      int               chan;
      logic [WIDTH-1:0] expVal;
      bit               expInc;
      bit               expDcr;
      bit               found;
      int               grantBad;
      logic [WIDTH-1:0] dacSeq [$];

      chan = rrPick(reqLines, modelLast);
      if (chan < 0) chan = 0;
      expVal = analog[IDXW'(chan)];
      expInc = modelValid[IDXW'(chan)] && (expVal > modelHist[IDXW'(chan)]);
      expDcr = modelValid[IDXW'(chan)] && (expVal < modelHist[IDXW'(chan)]);

      checkOutput("idleState", 32'(stateP), 32'(0));
      checkOutput("idleBusy", 32'(busy), 32'(0));
      checkOutput("idleGrant", 32'(grant), 32'(0));
      checkOutput("heldData", 32'(dataOut), 32'(modelLastData));

      found    = 1'b0;
      grantBad = 0;
      doneCyc  = cyc;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clockT);
         if (stateP == 2'b10) dacSeq.push_back(dacOut);
         if (stateP != 2'b00 && grant != (4'(1) << chan)) grantBad++;
         if (k == dropAfter) reqLines[IDXW'(chan)] = 1'b0;
         if (dataValid) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("doneSeen", 32'(found), 32'(1));
      if (!found) return;
      doneCyc = cyc;

      checkOutput("doneLatency", 32'(doneCyc - startCyc), 32'(LATENCY));
      checkOutput("dataOut", 32'(dataOut), 32'(expVal));
      checkOutput("chanOut", 32'(chanOut), 32'(chan));
      checkOutput("ack", 32'(ack), 32'(4'(1) << chan));
      checkOutput("inc", 32'(inc), 32'(expInc));
      checkOutput("dcr", 32'(dcr), 32'(expDcr));
      checkOutput("doneState", 32'(stateP), 32'(3));
      checkOutput("doneBusy", 32'(busy), 32'(1));
      checkOutput("grantHeld", 32'(grantBad), 32'(0));
      checkOutput("dacSteps", 32'(dacSeq.size()), 32'(WIDTH));
      for (int s = 0; s < dacSeq.size() && s < WIDTH; s++) begin
         checkOutput("dacStep", 32'(dacSeq[s]), 32'(dacExpected(expVal, WIDTH - 1 - s)));
      end

      modelHist[IDXW'(chan)]  = expVal;
      modelValid[IDXW'(chan)] = 1'b1;
      modelLast               = chan;
      modelLastData           = expVal;
      if (!holdReq) reqLines[IDXW'(chan)] = 1'b0;
   endtask

   initial begin
      int               done;
      int               prevDone;
      int               start;
      int               r;
      logic [WIDTH-1:0] ch2Vals [4];

      testsRun  = 0;
      failCount = 0;
      reset     = 1'b1;
      reqLines  = '0;
      for (int i = 0; i < CHANNELS; i++) analog[i] = WIDTH'($urandom_range(0, 255));
      clearModel();

      // Reset state and a single conversion of 0xA5 on channel 0.
      applyReset();
      analog[0] = 8'hA5;
      reqLines  = 4'b0001;
      applyStimulus(cyc, 1'b0, -1, done);
      @(negedge clockT);

      // Endpoints on channel 0: all-zero and all-one codes.
      analog[0] = 8'h00;
      reqLines  = 4'b0001;
      applyStimulus(cyc, 1'b0, -1, done);
      @(negedge clockT);
      analog[0] = 8'hFF;
      reqLines  = 4'b0001;
      applyStimulus(cyc, 1'b0, -1, done);
      @(negedge clockT);

      // All channels held: round-robin order and back-to-back spacing.
      applyReset();
      for (int i = 0; i < CHANNELS; i++) analog[i] = WIDTH'($urandom_range(0, 255));
      reqLines = 4'b1111;
      start    = cyc;
      prevDone = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(start, 1'b1, -1, done);
         checkOutput("rrOrder", 32'(chanOut), 32'(i % CHANNELS));
         if (i > 0) checkOutput("doneSpacing", 32'(done - prevDone), 32'(PERIOD));
         prevDone = done;
         if (i == 5) reqLines = '0;
         @(negedge clockT);
         start = cyc;
      end

      // Trend pulses on channel 2.
      ch2Vals[0] = 8'h40;
      ch2Vals[1] = 8'h60;
      ch2Vals[2] = 8'h60;
      ch2Vals[3] = 8'h10;
      for (int i = 0; i < 4; i++) begin
         analog[2] = ch2Vals[i];
         reqLines  = 4'b0100;
         applyStimulus(cyc, 1'b0, -1, done);
         if (i == 1) checkOutput("ch2Inc", 32'(inc), 32'(1));
         if (i == 2) checkOutput("ch2Equal", 32'({inc, dcr}), 32'(0));
         if (i == 3) checkOutput("ch2Dcr", 32'(dcr), 32'(1));
         @(negedge clockT);
      end

      // Reset while testing bit 5; history must be forgotten afterwards.
      analog[2] = 8'h40;
      reqLines  = 4'b0100;
      start     = cyc;
      repeat (SAMPLE_CYCLES + 3) @(negedge clockT);
      checkOutput("midState", 32'(stateP), 32'(2));
      checkOutput("midDac", 32'(dacOut), 32'(dacExpected(8'h40, 5)));
      reset = 1'b1;
      @(negedge clockT);
      checkResetState();
      reset = 1'b0;
      clearModel();
      applyStimulus(cyc, 1'b0, -1, done);
      checkOutput("postRstTrend", 32'({inc, dcr}), 32'(0));
      @(negedge clockT);

      // Request of channel 1 withdrawn during SAMPLE.
      analog[1] = WIDTH'($urandom_range(0, 255));
      reqLines  = 4'b0010;
      applyStimulus(cyc, 1'b0, 2, done);
      @(negedge clockT);

      // Randomized request patterns and analog levels.
      for (int it = 0; it < 40; it++) begin
         if (reqLines == '0) reqLines = 4'($urandom_range(1, 15));
         r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
         applyStimulus(cyc, 1'b0, r, done);
         reqLines = reqLines | 4'($urandom_range(0, 15));
         r = int'($urandom_range(0, 7));
         analog[IDXW'(modelLast)] = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : WIDTH'($urandom_range(0, 255));
         @(negedge clockT);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
